// File: rtl/wb_burst_master.sv
// Wishbone B4 pipelined initiator: moves one cache line per core request as a burst of beats.
// Optional ack watchdog that aborts a stuck burst: define WB_BURST_MASTER_TIMEOUT_EN.
module wb_burst_master #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [LINE_WIDTH-1:0]   i_req_data,
    output logic                    o_rsp_valid,
    output logic [LINE_WIDTH-1:0]   o_rsp_data,
    output logic                    o_rsp_err,
    output logic                    o_wb_cyc,
    output logic                    o_wb_stb,
    output logic                    o_wb_we,
    output logic [DATA_WIDTH/8-1:0] o_wb_sel,
    output logic [ADDR_WIDTH-1:0]   o_wb_addr,
    output logic [DATA_WIDTH-1:0]   o_wb_data,
    input  logic [DATA_WIDTH-1:0]   i_wb_data,
    input  logic                    i_wb_ack,
    input  logic                    i_wb_stall
);

    localparam int unsigned WORD_SIZE = DATA_WIDTH / 8;
    localparam int unsigned BEATS     = LINE_WIDTH / DATA_WIDTH;
    localparam int unsigned IDX_W     = $clog2(BEATS);
    localparam int unsigned CNT_W     = IDX_W + 1;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((LINE_WIDTH / 8) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic                    ready_q;
    logic [CNT_W-1:0]        issue_q, issue_d;
    logic [CNT_W-1:0]        ack_q, ack_d;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [LINE_WIDTH-1:0]   wline_q;
    logic [LINE_WIDTH-1:0]   rline_q;
    logic                    cyc_q;
    logic                    stb_q;
    logic [WORD_SIZE-1:0]    sel_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdat_q;
    logic                    rsp_valid_q;

    logic                    accept;
    logic                    issue_fire;
    logic                    ack_hit;
    logic                    last_ack;
    logic                    finish;
    logic [ADDR_WIDTH-1:0]   base_in;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic [DATA_WIDTH-1:0]   next_wdat;

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            rsp_err_q;
    logic            timeout_hit;
`endif

    always_comb begin
        accept     = i_req_valid && ready_q;
        base_in    = i_req_addr & ~OFF_MASK;
        issue_fire = stb_q && !i_wb_stall;
        issue_d    = issue_q + CNT_W'(issue_fire);
        // An ack with nothing outstanding belongs to no beat and is dropped.
        ack_hit    = (state_q == S_BUS) && i_wb_ack && (ack_q < issue_q);
        ack_d      = ack_q + CNT_W'(ack_hit);
        last_ack   = ack_hit && (ack_q == CNT_W'(BEATS - 1));
        next_addr  = base_q + ADDR_WIDTH'(issue_d) * ADDR_WIDTH'(WORD_SIZE);
        next_wdat  = wline_q[int'(issue_d[IDX_W-1:0]) * DATA_WIDTH +: DATA_WIDTH];
`ifdef WB_BURST_MASTER_TIMEOUT_EN
        wd_d        = i_wb_ack ? '0 : wd_q + WD_W'(1);
        timeout_hit = (state_q == S_BUS) && !i_wb_ack && (wd_q == WD_W'(TIMEOUT - 1));
        finish      = last_ack || timeout_hit;
`else
        finish      = last_ack;
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            issue_q     <= '0;
            ack_q       <= '0;
            we_q        <= 1'b0;
            base_q      <= '0;
            wline_q     <= '0;
            rline_q     <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            sel_q       <= '0;
            addr_q      <= '0;
            wdat_q      <= '0;
            rsp_valid_q <= 1'b0;
`ifdef WB_BURST_MASTER_TIMEOUT_EN
            wd_q        <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    rsp_valid_q <= 1'b0;
                    if (accept) begin
                        state_q <= S_BUS;
                        ready_q <= 1'b0;
                        issue_q <= '0;
                        ack_q   <= '0;
                        we_q    <= i_req_we;
                        base_q  <= base_in;
                        wline_q <= i_req_we ? i_req_data : '0;
                        rline_q <= '0;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        sel_q   <= '1;
                        addr_q  <= base_in;
                        wdat_q  <= i_req_we ? i_req_data[DATA_WIDTH-1:0] : '0;
`ifdef WB_BURST_MASTER_TIMEOUT_EN
                        wd_q    <= '0;
`endif
                    end
                end

                S_BUS: begin
                    issue_q <= issue_d;
                    ack_q   <= ack_d;
`ifdef WB_BURST_MASTER_TIMEOUT_EN
                    wd_q    <= wd_d;
`endif
                    if (ack_hit && !we_q) begin
                        rline_q[int'(ack_q[IDX_W-1:0]) * DATA_WIDTH +: DATA_WIDTH] <= i_wb_data;
                    end
                    // Address/data only advance on an accepted beat, so a stall holds them.
                    if (issue_fire) begin
                        if (issue_d == CNT_W'(BEATS)) begin
                            stb_q  <= 1'b0;
                            sel_q  <= '0;
                            wdat_q <= '0;
                        end else begin
                            addr_q <= next_addr;
                            wdat_q <= we_q ? next_wdat : '0;
                        end
                    end
                    if (finish) begin
                        state_q     <= S_DONE;
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        sel_q       <= '0;
                        wdat_q      <= '0;
                        we_q        <= 1'b0;
                        rsp_valid_q <= 1'b1;
`ifdef WB_BURST_MASTER_TIMEOUT_EN
                        rsp_err_q   <= timeout_hit;
`endif
                    end
                end

                S_DONE: begin
                    rsp_valid_q <= 1'b0;
`ifdef WB_BURST_MASTER_TIMEOUT_EN
                    rsp_err_q   <= 1'b0;
`endif
                    ready_q     <= 1'b1;
                    state_q     <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_req_ready = ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rline_q;
`ifdef WB_BURST_MASTER_TIMEOUT_EN
    assign o_rsp_err   = rsp_err_q;
`else
    assign o_rsp_err   = 1'b0;
`endif
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = stb_q;
    assign o_wb_we     = we_q;
    assign o_wb_sel    = sel_q;
    assign o_wb_addr   = addr_q;
    assign o_wb_data   = wdat_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Self-checking bench for wb_burst_master: vector table, hand-written corner sequences and
// randomized bursts against a line-level reference model with a pipelined slave model.
module tb_wb_burst_master;

    localparam int NB = 8;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         i_req_valid = 1'b0;
    logic         o_req_ready;
    logic         i_req_we = 1'b0;
    logic [31:0]  i_req_addr = '0;
    logic [127:0] i_req_data = '0;
    logic         o_rsp_valid;
    logic [127:0] o_rsp_data;
    logic         o_rsp_err;
    logic         o_wb_cyc;
    logic         o_wb_stb;
    logic         o_wb_we;
    logic [1:0]   o_wb_sel;
    logic [31:0]  o_wb_addr;
    logic [15:0]  o_wb_data;
    logic [15:0]  i_wb_data = '0;
    logic         i_wb_ack = 1'b0;
    logic         i_wb_stall = 1'b0;

    always #5 clk = ~clk;

    wb_burst_master #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(32),
        .LINE_WIDTH(128),
        .TIMEOUT   (16)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready),
        .i_req_we   (i_req_we),
        .i_req_addr (i_req_addr),
        .i_req_data (i_req_data),
        .o_rsp_valid(o_rsp_valid),
        .o_rsp_data (o_rsp_data),
        .o_rsp_err  (o_rsp_err),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_sel   (o_wb_sel),
        .o_wb_addr  (o_wb_addr),
        .o_wb_data  (o_wb_data),
        .i_wb_data  (i_wb_data),
        .i_wb_ack   (i_wb_ack),
        .i_wb_stall (i_wb_stall)
    );

    int compared = 0;
    int mismatched = 0;
    int cyc_n = 0;

    // slave behaviour knobs
    int lat = 1, stall_first = 0, stall_pct = 0, ack_limit = 1000;
    int acks_given = 0, slave_beat = 0, last_ack_cyc = 0;
    bit seq_data = 0, spur_en = 0;

    typedef struct { int due; logic [15:0] d; } pend_t;
    typedef struct { logic [31:0] a; logic [15:0] d; logic we; logic [1:0] sel; } beat_t;
    typedef struct { int c; logic [127:0] d; logic err; } rsp_t;
    pend_t pend[$];
    beat_t beats[$];
    rsp_t  rsps[$];
    int    acc[$];

    logic [31:0]  cur_base;
    logic         cur_we;
    logic [127:0] cur_wdata;
    int           beat_off = 0;

    function automatic logic [15:0] slave_word(logic [31:0] a);
        return a[15:0] ^ a[31:16] ^ 16'h5A5A;
    endfunction

    function automatic logic [127:0] model_line(logic [31:0] base, logic we, int nacks, bit seq);
        logic [127:0] l = '0;
        for (int k = 0; k < NB; k++)
            if (!we && k < nacks)
                l[k*16 +: 16] = seq ? 16'h1000 + 16'(k) : slave_word(base + 32'(2 * k));
        return l;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc_n);
        end
    endtask

    // One clock: inputs for the cycle are chosen at the falling edge from registered outputs.
    task automatic tick();
        pend_t p;
        int k;
        if (i_req_valid && o_req_ready) acc.push_back(cyc_n);
        @(negedge clk);
        cyc_n++;
        if (!o_wb_cyc) pend.delete();
        i_wb_ack  = 1'b0;
        i_wb_data = 16'($urandom);
        if (pend.size() > 0 && pend[0].due <= cyc_n && acks_given < ack_limit) begin
            p = pend.pop_front();
            i_wb_ack = 1'b1;
            i_wb_data = p.d;
            acks_given++;
            last_ack_cyc = cyc_n;
        end else if (spur_en && o_wb_cyc && pend.size() == 0) begin
            i_wb_ack = 1'b1;
            i_wb_data = 16'hDEAD;
        end
        i_wb_stall = 1'b0;
        if (o_wb_stb) begin
            if (stall_first > 0) begin
                i_wb_stall = 1'b1;
                stall_first--;
            end else if (int'($urandom_range(99)) < stall_pct) begin
                i_wb_stall = 1'b1;
            end
        end
        if (o_wb_cyc && o_wb_stb) begin
            k = (beats.size() - beat_off) % NB;
            if (i_wb_stall) begin
                check("stall_addr", o_wb_addr, cur_base + 32'(2 * k));
                check("stall_data", o_wb_data, cur_we ? cur_wdata[k*16 +: 16] : 16'h0);
            end else begin
                beats.push_back('{o_wb_addr, o_wb_data, o_wb_we, o_wb_sel});
                p.due = cyc_n + lat;
                p.d = seq_data ? 16'h1000 + 16'(slave_beat) : slave_word(o_wb_addr);
                slave_beat++;
                pend.push_back(p);
            end
        end
        if (o_rsp_valid) rsps.push_back('{cyc_n, o_rsp_data, o_rsp_err});
    endtask

    task automatic check_line(input int off, input logic [31:0] base, input logic we,
                              input logic [127:0] wd, input int nacks, input rsp_t r);
        for (int k = 0; k < NB; k++) begin
            if (off + k < beats.size()) begin
                check("beat_addr", beats[off+k].a, base + 32'(2 * k));
                check("beat_data", beats[off+k].d, we ? wd[k*16 +: 16] : 16'h0);
                check("beat_we", beats[off+k].we, we);
                check("beat_sel", beats[off+k].sel, 2'b11);
            end
        end
        check("rsp_data", r.d, model_line(base, we, nacks, seq_data));
        check("rsp_err", r.err, nacks < NB);
    endtask

    task automatic start_req(input logic we, input logic [31:0] addr, input logic [127:0] wd,
                             input logic [31:0] base);
        int g = 0;
        beats.delete(); rsps.delete(); acc.delete();
        beat_off = 0; slave_beat = 0; acks_given = 0;
        cur_base = base; cur_we = we; cur_wdata = wd;
        i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr; i_req_data = wd;
        while (acc.size() == 0 && g < 50) begin tick(); g++; end
        i_req_valid = 1'b0;
        check("accepted", acc.size(), 1);
    endtask

    task automatic xfer(input logic we, input logic [31:0] addr, input logic [127:0] wd,
                        input int nacks, input logic [31:0] base, output int latency);
        int g = 0;
        ack_limit = nacks;
        start_req(we, addr, wd, base);
        while (rsps.size() == 0 && g < 2000) begin tick(); g++; end
        check("rsp_seen", rsps.size(), 1);
        check("beat_count", beats.size(), NB);
        latency = -1;
        if (rsps.size() > 0 && acc.size() > 0) begin
            latency = rsps[0].c - acc[0];
            check_line(0, base, we, wd, nacks, rsps[0]);
        end
        tick();
        tick();
        check("rsp_pulse_once", rsps.size(), 1);
        check("ready_after", o_req_ready, 1'b1);
        check("rsp_data_held", o_rsp_data, model_line(base, we, nacks, seq_data));
        ack_limit = 1000;
    endtask

    typedef struct {
        bit we; logic [31:0] addr; int lat; int stall_first; int stall_pct;
        bit seq; bit spur; logic [31:0] exp_base; int exp_lat;
    } vec_t;

    initial begin
        #900000;
        $display("FAIL global_time_limit: simulation did not finish, cycle %0d", cyc_n);
        $fatal(1, "time limit");
    end

    initial begin
        vec_t tbl[6];
        int l, g;
        logic [127:0] wd;
        logic [31:0] a;
        logic w;

        tbl[0] = '{1'b0, 32'h0000_1234, 1, 0, 0,  1'b1, 1'b0, 32'h0000_1230, 10};
        tbl[1] = '{1'b1, 32'h0000_2008, 1, 3, 0,  1'b0, 1'b0, 32'h0000_2000, 13};
        tbl[2] = '{1'b0, 32'h0000_0040, 4, 0, 0,  1'b0, 1'b0, 32'h0000_0040, 13};
        tbl[3] = '{1'b0, 32'hFFFF_FFFF, 1, 0, 0,  1'b0, 1'b0, 32'hFFFF_FFF0, 10};
        tbl[4] = '{1'b1, 32'h8000_001F, 2, 0, 0,  1'b0, 1'b0, 32'h8000_0010, 11};
        tbl[5] = '{1'b0, 32'h0000_0C0A, 1, 0, 50, 1'b0, 1'b1, 32'h0000_0C00, -1};

        // reset state
        tick(); tick();
        check("rst_ready", o_req_ready, 1'b1);
        check("rst_cyc", o_wb_cyc, 1'b0);
        check("rst_stb", o_wb_stb, 1'b0);
        check("rst_we", o_wb_we, 1'b0);
        check("rst_sel", o_wb_sel, 2'b00);
        check("rst_addr", o_wb_addr, 32'h0);
        check("rst_wdata", o_wb_data, 16'h0);
        check("rst_rsp_valid", o_rsp_valid, 1'b0);
        check("rst_rsp_data", o_rsp_data, 128'h0);
        check("rst_rsp_err", o_rsp_err, 1'b0);
        n_rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            lat = tbl[i].lat; stall_first = tbl[i].stall_first; stall_pct = tbl[i].stall_pct;
            seq_data = tbl[i].seq; spur_en = tbl[i].spur;
            for (int k = 0; k < NB; k++) wd[k*16 +: 16] = 16'h00A0 + 16'(k);
            xfer(tbl[i].we, tbl[i].addr, wd, NB, tbl[i].exp_base, l);
            if (tbl[i].exp_lat >= 0) check($sformatf("latency_vec%0d", i), l, tbl[i].exp_lat);
        end
        seq_data = 0; spur_en = 0; stall_pct = 0; stall_first = 0;

        for (int i = 0; i < 25; i++) begin
            lat = $urandom_range(1, 4);
            stall_pct = $urandom_range(0, 40);
            spur_en = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = $urandom;
            wd = {$urandom, $urandom, $urandom, $urandom};
            xfer(w, a, wd, NB, a & ~32'hF, l);
            check("rand_min_latency", l >= NB + 2, 1'b1);
        end
        spur_en = 0; stall_pct = 0; lat = 1;

        // back-to-back reads with valid held high
        beats.delete(); rsps.delete(); acc.delete(); slave_beat = 0; beat_off = 0; acks_given = 0;
        cur_base = 32'h7000; cur_we = 1'b0; cur_wdata = '0;
        i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h0000_7000;
        g = 0;
        while (acc.size() < 1 && g < 50) begin tick(); g++; end
        i_req_addr = 32'h0000_7124;
        g = 0;
        while (acc.size() < 2 && g < 100) begin tick(); g++; end
        i_req_valid = 1'b0;
        g = 0;
        while (rsps.size() < 2 && g < 200) begin tick(); g++; end
        check("b2b_accepts", acc.size(), 2);
        check("b2b_rsps", rsps.size(), 2);
        check("b2b_beats", beats.size(), 2 * NB);
        if (acc.size() == 2 && rsps.size() == 2) begin
            check("b2b_gap", acc[1] - rsps[0].c, 1);
            check_line(0, 32'h0000_7000, 1'b0, '0, NB, rsps[0]);
            check_line(NB, 32'h0000_7120, 1'b0, '0, NB, rsps[1]);
        end
        tick(); tick();

        // reset in the middle of a burst
        start_req(1'b0, 32'h0000_9876, '0, 32'h0000_9870);
        g = 0;
        while (beats.size() < 3 && g < 50) begin tick(); g++; end
        n_rst = 1'b0;
        #1;
        check("midrst_cyc", o_wb_cyc, 1'b0);
        check("midrst_stb", o_wb_stb, 1'b0);
        check("midrst_ready", o_req_ready, 1'b1);
        tick(); tick();
        check("midrst_rsp_valid", o_rsp_valid, 1'b0);
        check("midrst_no_rsp", rsps.size(), 0);
        n_rst = 1'b1;
        tick();
        xfer(1'b0, 32'h0000_9876, '0, NB, 32'h0000_9870, l);
        check("after_rst_latency", l, NB + 2);

`ifdef WB_BURST_MASTER_TIMEOUT_EN
        xfer(1'b0, 32'h0000_0500, '0, 2, 32'h0000_0500, l);
        if (rsps.size() > 0) check("timeout_gap", rsps[0].c - last_ack_cyc, 17);
`else
        ack_limit = 2;
        start_req(1'b0, 32'h0000_0500, '0, 32'h0000_0500);
        repeat (1000) tick();
        check("hang_cyc", o_wb_cyc, 1'b1);
        check("hang_no_rsp", rsps.size(), 0);
        check("hang_err_tied", o_rsp_err, 1'b0);
        n_rst = 1'b0;
        tick();
        check("hang_rst_cyc", o_wb_cyc, 1'b0);
        n_rst = 1'b1;
        ack_limit = 1000;
        tick(); tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
